lcd_fill_seq: RTL and testbench
===============================

LCD_FILL_SEQ -- requirements
Module: lcd_fill_seq

Interface
REQ-001 Parameter COORD_W, default 9, coordinate width in bits (covers 320x240 panels).
REQ-002 Parameter CNT_W, default 2*COORD_W+1, pixel-counter width.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  fill request present.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 x0, x1  in  COORD_W  column bounds, inclusive.
REQ-008 y0, y1  in  COORD_W  row bounds, inclusive.
REQ-009 color  in  16  RGB565 fill colour.
REQ-010 spi_start  out  1  one-cycle pulse; launches a byte on the SPI byte master.
REQ-011 spi_data  out  8  byte to transmit.
REQ-012 spi_dc  out  1  0 = command byte, 1 = data byte.
REQ-013 spi_done  in  1  one-cycle pulse from the SPI master when the byte is shifted out.
REQ-014 busy  out  1  high from request acceptance until done.
REQ-015 done  out  1  one-cycle pulse when the fill completes.

Function
REQ-016 A request SHALL be accepted on a cycle where req_valid and req_ready are both 1; req_ready SHALL be 1 only in IDLE.
REQ-017 On acceptance, x0/x1/y0/y1/color SHALL be latched; if x1<x0 or y1<y0, each pair SHALL be swapped so that lo<=hi.
REQ-018 Byte order SHALL be: 0x2A(cmd), xlo[15:8], xlo[7:0], xhi[15:8], xhi[7:0], 0x2B(cmd), ylo and yhi in the same format, 0x2C(cmd), then N repetitions of color[15:8], color[7:0]. Coordinates SHALL be zero-extended to 16 bits.
REQ-019 N SHALL be (xhi-xlo+1)*(yhi-ylo+1), computed in CNT_W bits without overflow; total bytes = 11+2N.
REQ-020 States SHALL be IDLE, SETUP (window/command bytes, index 0..10), PIXEL (colour bytes), WAIT (awaiting spi_done).
REQ-021 Transitions: IDLE->SETUP on accept; SETUP->WAIT on issuing a byte; WAIT->SETUP or PIXEL on spi_done; PIXEL->WAIT on issuing a byte; WAIT->IDLE on spi_done of the last byte.
REQ-022 spi_start SHALL pulse exactly once per byte; spi_data and spi_dc SHALL be valid on the spi_start cycle and held stable until spi_done.
REQ-023 The first spi_start SHALL occur 1 cycle after acceptance; each next spi_start SHALL occur 1 cycle after the preceding spi_done.
REQ-024 spi_done SHALL be ignored outside WAIT.
REQ-025 done SHALL pulse the cycle after the final spi_done; busy SHALL fall and req_ready SHALL rise in that same cycle.
REQ-026 A 1x1 fill (x0=x1, y0=y1) SHALL send exactly 13 bytes.
REQ-027 req_valid held during busy SHALL have no effect; new inputs SHALL not disturb the latched request.

Reset
REQ-028 On reset, the block SHALL enter IDLE; spi_start=0, spi_data=0, spi_dc=0, busy=0, done=0, req_ready=1, and counters cleared.
REQ-029 Reset mid-operation SHALL abort immediately, with no further spi_start; the partial transfer SHALL be discarded.

Structure
REQ-030 Shared package lcd_pkg SHALL hold the opcodes (CASET=0x2A, RASET=0x2B, RAMWR=0x2C), the state enum, and the COORD_W default.
REQ-031 One sub-module, lcd_pix_counter (loadable CNT_W down-counter with zero flag), SHALL count remaining pixels.

Verification
REQ-032 x0=0,x1=0,y0=0,y1=0,color=0xF800 -> bytes 2A,00,00,00,00,2B,00,00,00,00,2C,F8,00; done after 13th spi_done.
REQ-033 x0=10,x1=19,y0=5,y1=14,color=0x07E0 -> 11 setup bytes with 0A/13/05/0E lows, then 200 data bytes alternating 07,E0.
REQ-034 x0=300,x1=4 -> swapped window 0004..012C emitted (bytes 00,04,01,2C); N=297*rows.
REQ-035 spi_done delayed 0..20 random cycles, plus stray spi_done while in SETUP -> data/dc stable, no extra or missing bytes.
REQ-036 Reset asserted after 5th byte -> spi_start stays 0, req_ready=1 next cycle; new request then completes correctly.
REQ-037 req_valid held high during busy with changing coordinates -> only the first request is transmitted; second accepted after done.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD window-fill sequencer: panel opcodes,
// sequencer states and the setup-byte lookup.
package lcd_pkg;

  localparam int LCD_COORD_W = 9;

  localparam logic [7:0] CASET = 8'h2A;
  localparam logic [7:0] RASET = 8'h2B;
  localparam logic [7:0] RAMWR = 8'h2C;

  // Byte indices 0..10 are the window/command bytes; 11 marks the colour stream.
  localparam logic [3:0] SETUP_LAST = 4'd10;
  localparam logic [3:0] PIX_IDX    = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PIXEL = 2'd2,
    ST_WAIT  = 2'd3
  } lcd_state_e;

  // Returns {dc, data} for setup byte idx.
  function automatic logic [8:0] setup_byte(input logic [3:0] idx,
                                            input logic [15:0] xlo,
                                            input logic [15:0] xhi,
                                            input logic [15:0] ylo,
                                            input logic [15:0] yhi);
    logic [8:0] word;
    case (idx)
      4'd0:    word = {1'b0, CASET};
      4'd1:    word = {1'b1, xlo[15:8]};
      4'd2:    word = {1'b1, xlo[7:0]};
      4'd3:    word = {1'b1, xhi[15:8]};
      4'd4:    word = {1'b1, xhi[7:0]};
      4'd5:    word = {1'b0, RASET};
      4'd6:    word = {1'b1, ylo[15:8]};
      4'd7:    word = {1'b1, ylo[7:0]};
      4'd8:    word = {1'b1, yhi[15:8]};
      4'd9:    word = {1'b1, yhi[7:0]};
      4'd10:   word = {1'b0, RAMWR};
      default: word = 9'd0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/lcd_pix_counter.sv
// Loadable down-counter of remaining pixels; stops at zero and flags it.
module lcd_pix_counter #(
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_fill_seq.sv
// Streams a CASET/RASET/RAMWR window setup followed by a solid colour fill
// to an SPI byte master, one byte per start/done handshake.
module lcd_fill_seq
  import lcd_pkg::*;
#(
  parameter int COORD_W = LCD_COORD_W,
  parameter int CNT_W   = 2*COORD_W+1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] y1,
  input  logic [15:0]        color,
  output logic               spi_start,
  output logic [7:0]         spi_data,
  output logic               spi_dc,
  input  logic               spi_done,
  output logic               busy,
  output logic               done
);

  lcd_state_e         state_reg;
  logic [COORD_W-1:0] xlo_reg, xhi_reg, ylo_reg, yhi_reg;
  logic [15:0]        color_reg;
  logic [3:0]         idx_reg;
  logic               pix_lo_reg;
  logic               done_reg;

  logic [COORD_W-1:0] xlo_in, xhi_in, ylo_in, yhi_in;
  logic [CNT_W-1:0]   span_x, span_y, pix_init, cnt_value;
  logic               accept, cnt_dec, cnt_zero;
  logic [8:0]         setup_word, tx_word;

  always_comb begin
    xlo_in = (x1 < x0) ? x1 : x0;
    xhi_in = (x1 < x0) ? x0 : x1;
    ylo_in = (y1 < y0) ? y1 : y0;
    yhi_in = (y1 < y0) ? y0 : y1;
  end

  // Counter holds pixels remaining after the current one, so zero marks the last.
  assign span_x   = CNT_W'(xhi_in) - CNT_W'(xlo_in) + CNT_W'(1);
  assign span_y   = CNT_W'(yhi_in) - CNT_W'(ylo_in) + CNT_W'(1);
  assign pix_init = span_x * span_y - CNT_W'(1);

  assign accept  = req_valid && (state_reg == ST_IDLE);
  assign cnt_dec = (state_reg == ST_WAIT) && spi_done && (idx_reg == PIX_IDX) && pix_lo_reg;

  lcd_pix_counter #(.CNT_W(CNT_W)) u_pix_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (pix_init),
    .dec      (cnt_dec),
    .count    (cnt_value),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      xlo_reg    <= '0;
      xhi_reg    <= '0;
      ylo_reg    <= '0;
      yhi_reg    <= '0;
      color_reg  <= '0;
      idx_reg    <= '0;
      pix_lo_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            xlo_reg    <= xlo_in;
            xhi_reg    <= xhi_in;
            ylo_reg    <= ylo_in;
            yhi_reg    <= yhi_in;
            color_reg  <= color;
            idx_reg    <= '0;
            pix_lo_reg <= 1'b0;
            state_reg  <= ST_SETUP;
          end
        end
        ST_SETUP: state_reg <= ST_WAIT;
        ST_PIXEL: state_reg <= ST_WAIT;
        ST_WAIT: begin
          if (spi_done) begin
            if (idx_reg < SETUP_LAST) begin
              idx_reg   <= idx_reg + 4'd1;
              state_reg <= ST_SETUP;
            end else if (idx_reg == SETUP_LAST) begin
              idx_reg    <= PIX_IDX;
              pix_lo_reg <= 1'b0;
              state_reg  <= ST_PIXEL;
            end else if (!pix_lo_reg) begin
              pix_lo_reg <= 1'b1;
              state_reg  <= ST_PIXEL;
            end else if (cnt_zero) begin
              idx_reg    <= '0;
              pix_lo_reg <= 1'b0;
              done_reg   <= 1'b1;
              state_reg  <= ST_IDLE;
            end else begin
              pix_lo_reg <= 1'b0;
              state_reg  <= ST_PIXEL;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Byte is decoded from held registers, so it stays put through WAIT.
  assign setup_word = setup_byte(idx_reg, 16'(xlo_reg), 16'(xhi_reg),
                                 16'(ylo_reg), 16'(yhi_reg));

  always_comb begin
    tx_word = 9'd0;
    if (state_reg != ST_IDLE) begin
      if (idx_reg == PIX_IDX) begin
        tx_word = {1'b1, (pix_lo_reg ? color_reg[7:0] : color_reg[15:8])};
      end else begin
        tx_word = setup_word;
      end
    end
  end

  assign spi_dc    = tx_word[8];
  assign spi_data  = tx_word[7:0];
  assign spi_start = (state_reg == ST_SETUP) || (state_reg == ST_PIXEL);
  assign busy      = (state_reg != ST_IDLE);
  assign req_ready = (state_reg == ST_IDLE);
  assign done      = done_reg;

endmodule

// File: tb/tb_lcd_fill_seq.sv
// Self-checking bench for lcd_fill_seq: randomized handshake timing checked
// against a byte-stream model built directly from the window/colour rules.
module tb_lcd_fill_seq;

  localparam int COORD_W = 9;

  logic               clk = 1'b0;
  logic               reset;
  logic               req_valid;
  logic               req_ready;
  logic [COORD_W-1:0] x0, x1, y0, y1;
  logic [15:0]        color;
  logic               spi_start;
  logic [7:0]         spi_data;
  logic               spi_dc;
  logic               spi_done;
  logic               busy;
  logic               done;

  int check_count = 0;
  int error_count = 0;

  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  lcd_fill_seq #(.COORD_W(COORD_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .x0        (x0),
    .x1        (x1),
    .y0        (y0),
    .y1        (y1),
    .color     (color),
    .spi_start (spi_start),
    .spi_data  (spi_data),
    .spi_dc    (spi_dc),
    .spi_done  (spi_done),
    .busy      (busy),
    .done      (done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_coord(input int v);
    logic [15:0] w;
    w = 16'(v);
    exp_q.push_back({1'b1, w[15:8]});
    exp_q.push_back({1'b1, w[7:0]});
  endtask

  // Reference byte stream: window order fixed by lo<=hi, then one colour pair per pixel.
  task automatic build_expected(input int ax0, input int ax1, input int ay0, input int ay1,
                                input logic [15:0] c);
    int xl, xh, yl, yh, n;
    xl = (ax0 < ax1) ? ax0 : ax1;
    xh = (ax0 < ax1) ? ax1 : ax0;
    yl = (ay0 < ay1) ? ay0 : ay1;
    yh = (ay0 < ay1) ? ay1 : ay0;
    exp_q.delete();
    exp_q.push_back(9'h02A);
    push_coord(xl);
    push_coord(xh);
    exp_q.push_back(9'h02B);
    push_coord(yl);
    push_coord(yh);
    exp_q.push_back(9'h02C);
    n = (xh - xl + 1) * (yh - yl + 1);
    for (int p = 0; p < n; p++) begin
      exp_q.push_back({1'b1, c[15:8]});
      exp_q.push_back({1'b1, c[7:0]});
    end
  endtask

  task automatic run_fill(input int ax0, input int ax1, input int ay0, input int ay1,
                          input logic [15:0] c, input int max_delay, input bit stray,
                          input bit hold, input int abort_at);
    int nbytes;
    build_expected(ax0, ax1, ay0, ay1, c);
    nbytes = exp_q.size();
    x0 = COORD_W'(ax0);
    x1 = COORD_W'(ax1);
    y0 = COORD_W'(ay0);
    y1 = COORD_W'(ay1);
    color = c;
    req_valid = 1'b1;
    check_val("ready_before_req", 32'(req_ready), 32'd1);
    step();
    if (!hold) req_valid = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      logic [8:0] held;
      bit clean;
      int d;
      check_val("start_pulse", 32'(spi_start), 32'd1);
      check_val("byte", 32'({spi_dc, spi_data}), 32'(exp_q[i]));
      held = {spi_dc, spi_data};
      if (stray) spi_done = 1'b1;
      step();
      spi_done = 1'b0;
      if (abort_at == i) begin
        reset = 1'b1;
        #1;
        check_val("abort_start", 32'(spi_start), 32'd0);
        check_val("abort_ready", 32'(req_ready), 32'd1);
        check_val("abort_busy", 32'(busy), 32'd0);
        step();
        reset = 1'b0;
        clean = 1'b1;
        for (int k = 0; k < 6; k++) begin
          if (spi_start || done || busy) clean = 1'b0;
          step();
        end
        check_val("abort_quiet", 32'(clean), 32'd1);
        $display("fill x %0d..%0d y %0d..%0d aborted after %0d bytes", ax0, ax1, ay0, ay1, i + 1);
        return;
      end
      d = $urandom_range(max_delay, 0);
      clean = 1'b1;
      for (int k = 0; k < d; k++) begin
        if (hold) begin
          x0 = COORD_W'($urandom);
          x1 = COORD_W'($urandom);
          y0 = COORD_W'($urandom);
          y1 = COORD_W'($urandom);
          color = 16'($urandom);
        end
        if (spi_start || ({spi_dc, spi_data} !== held) || !busy) clean = 1'b0;
        step();
      end
      if (spi_start || ({spi_dc, spi_data} !== held) || !busy) clean = 1'b0;
      check_val("wait_stable", 32'(clean), 32'd1);
      spi_done = 1'b1;
      step();
      spi_done = 1'b0;
    end
    check_val("done_pulse", 32'(done), 32'd1);
    check_val("busy_low", 32'(busy), 32'd0);
    check_val("ready_back", 32'(req_ready), 32'd1);
    check_val("no_extra_start", 32'(spi_start), 32'd0);
    $display("fill x %0d..%0d y %0d..%0d color %04h: %0d bytes", ax0, ax1, ay0, ay1, c, nbytes);
    if (!hold) begin
      step();
      check_val("done_single", 32'(done), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    spi_done = 1'b0;
    x0 = '0;
    x1 = '0;
    y0 = '0;
    y1 = '0;
    color = '0;
    step();
    step();
    check_val("rst_ready", 32'(req_ready), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_start", 32'(spi_start), 32'd0);
    check_val("rst_data", 32'(spi_data), 32'd0);
    check_val("rst_dc", 32'(spi_dc), 32'd0);
    reset = 1'b0;
    step();

    // A stray spi_done in IDLE must not start anything.
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    check_val("idle_stray_busy", 32'(busy), 32'd0);
    check_val("idle_stray_start", 32'(spi_start), 32'd0);

    run_fill(0, 0, 0, 0, 16'hF800, 3, 1'b0, 1'b0, -1);
    run_fill(10, 19, 5, 14, 16'h07E0, 2, 1'b0, 1'b0, -1);
    run_fill(300, 4, 7, 7, 16'h1234, 1, 1'b0, 1'b0, -1);
    run_fill(5, 9, 20, 18, 16'hBEEF, 20, 1'b1, 1'b0, -1);
    run_fill(1, 2, 3, 4, 16'hABCD, 4, 1'b0, 1'b0, 4);
    run_fill(7, 3, 2, 2, 16'h5A5A, 2, 1'b0, 1'b0, -1);
    run_fill(2, 5, 1, 2, 16'hC3C3, 3, 1'b0, 1'b1, -1);
    run_fill(9, 8, 7, 6, 16'h0F0F, 3, 1'b0, 1'b0, -1);

    for (int t = 0; t < 6; t++) begin
      int xa, xb, ya, yb, tmp;
      xa = $urandom_range(313, 0);
      xb = xa + $urandom_range(6, 0);
      ya = $urandom_range(233, 0);
      yb = ya + $urandom_range(6, 0);
      if ($urandom_range(1, 0) == 1) begin
        tmp = xa; xa = xb; xb = tmp;
      end
      if ($urandom_range(1, 0) == 1) begin
        tmp = ya; ya = yb; yb = tmp;
      end
      run_fill(xa, xb, ya, yb, 16'($urandom), 20, 1'($urandom_range(1, 0)), 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
